// File: rtl/batt_pkg.sv
// Shared types and helpers for the battery bar controller.
package batt_pkg;

    localparam int LVL_W = 4;
    localparam logic [LVL_W-1:0] LVL_MAX = 4'd8;

    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        LOW_BLINK = 2'd1,
        CHARGE    = 2'd2
    } state_t;

    // Thermometer code: level n lights the lowest n LEDs, saturating at 8.
    function automatic logic [7:0] thermometer(input logic [LVL_W-1:0] lvl);
        logic [7:0] t;
        t = '0;
        for (int i = 0; i < 8; i++) begin
            if (int'(lvl) > i) t[i] = 1'b1;
        end
        return t;
    endfunction

endpackage

// File: rtl/batt_level_filter.sv
// Averages ADC samples per window, quantises to 0..8 and debounces the
// displayed level with a hold count.
module batt_level_filter
    import batt_pkg::*;
#(
    parameter int ADC_W    = 8,
    parameter int AVG_LOG2 = 2,
    parameter int HOLD_WIN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adc_valid,
    input  logic [ADC_W-1:0] adc_data,
    output logic [LVL_W-1:0] level,
    output logic             first_done
);

    localparam int ACC_W  = ADC_W + AVG_LOG2;
    localparam int CNT_W  = AVG_LOG2 + 1;
    localparam int HCNT_W = (HOLD_WIN > 1) ? $clog2(HOLD_WIN + 1) : 1;
    localparam logic [CNT_W-1:0] WIN_N = CNT_W'(1 << AVG_LOG2);

    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               win_done;
    logic [ADC_W-1:0]   avg;
    logic [ADC_W+3:0]   prod;
    logic [LVL_W-1:0]   raw;
    logic [LVL_W-1:0]   cand;
    logic [HCNT_W-1:0]  hold;
    logic [HCNT_W-1:0]  hold_nxt;

    // A full count is seen the cycle after the last sample of the window.
    assign win_done = (cnt == WIN_N);
    assign avg      = acc[ACC_W-1:AVG_LOG2];
    assign prod     = {4'b0000, avg} * (ADC_W+4)'(9);
    assign raw      = prod[ADC_W+3:ADC_W];

    // A new or changed candidate restarts the persistence count at 1.
    assign hold_nxt = (raw != cand || hold == '0) ? HCNT_W'(1) : hold + HCNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            cnt        <= '0;
            level      <= '0;
            first_done <= 1'b0;
            cand       <= '0;
            hold       <= '0;
        end else begin
            if (win_done) begin
                acc <= adc_valid ? ACC_W'(adc_data) : '0;
                cnt <= adc_valid ? CNT_W'(1) : '0;
            end else if (adc_valid) begin
                acc <= acc + ACC_W'(adc_data);
                cnt <= cnt + CNT_W'(1);
            end

            if (win_done) begin
                if (!first_done) begin
                    level      <= raw;
                    first_done <= 1'b1;
                    hold       <= '0;
                end else if (raw == level) begin
                    hold <= '0;
                end else if (int'(hold_nxt) >= HOLD_WIN) begin
                    level <= raw;
                    cand  <= raw;
                    hold  <= '0;
                end else begin
                    cand <= raw;
                    hold <= hold_nxt;
                end
            end
        end
    end

endmodule

// File: rtl/battery_bar_ctrl.sv
// Battery LED bar sequencer: level filter, tick prescaler, mode FSM, bar driver.
// Optional shutdown request output is enabled by BATT_BAR_SHUTDOWN_EN.
module battery_bar_ctrl
    import batt_pkg::*;
#(
    parameter int ADC_W       = 8,
    parameter int AVG_LOG2    = 2,
    parameter int HOLD_WIN    = 3,
    parameter int TICK_DIV    = 50000,
    parameter int BLINK_TICKS = 8,
    parameter int LOW_LEVEL   = 2
`ifdef BATT_BAR_SHUTDOWN_EN
    ,
    parameter int SHUT_TICKS  = 64
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adc_valid,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             charging,
    output logic [3:0]       level,
    output logic [7:0]       led_bar,
    output logic             low_batt
`ifdef BATT_BAR_SHUTDOWN_EN
    ,
    output logic             shutdown_req
`endif
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [LVL_W-1:0] LOW_L = LVL_W'(LOW_LEVEL);

    logic             first_done;
    logic [TW-1:0]    div_cnt;
    logic             tick;
    state_t           state_q;
    state_t           state_d;
    logic [BW-1:0]    blink_cnt;
    logic             blink_off;
    logic [LVL_W-1:0] anim;
    logic [7:0]       bar_d;

    batt_level_filter #(
        .ADC_W    (ADC_W),
        .AVG_LOG2 (AVG_LOG2),
        .HOLD_WIN (HOLD_WIN)
    ) u_filter (
        .clk        (clk),
        .rst        (rst),
        .adc_valid  (adc_valid),
        .adc_data   (adc_data),
        .level      (level),
        .first_done (first_done)
    );

    assign tick = (div_cnt == TW'(TICK_DIV - 1));

    always_comb begin
        state_d = state_q;
        bar_d   = thermometer(level);
        case (state_q)
            NORMAL: begin
                if (charging)                          state_d = CHARGE;
                else if (first_done && level <= LOW_L) state_d = LOW_BLINK;
            end
            LOW_BLINK: begin
                if (charging)           state_d = CHARGE;
                else if (level > LOW_L) state_d = NORMAL;
                if (blink_off) bar_d = '0;
            end
            CHARGE: begin
                if (!charging) state_d = NORMAL;
                bar_d = thermometer(anim);
            end
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= NORMAL;
            div_cnt   <= '0;
            blink_cnt <= '0;
            blink_off <= 1'b0;
            anim      <= '0;
            led_bar   <= '0;
            low_batt  <= 1'b0;
        end else begin
            state_q  <= state_d;
            led_bar  <= bar_d;
            low_batt <= (state_q == LOW_BLINK);
            div_cnt  <= tick ? '0 : div_cnt + TW'(1);

            if (state_d == LOW_BLINK && state_q != LOW_BLINK) begin
                blink_cnt <= '0;
                blink_off <= 1'b0;
            end else if (state_q == LOW_BLINK && tick) begin
                if (int'(blink_cnt) >= BLINK_TICKS - 1) begin
                    blink_cnt <= '0;
                    blink_off <= ~blink_off;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end

            // Level changes during CHARGE are only picked up at the wrap.
            if (state_d == CHARGE && state_q != CHARGE) begin
                anim <= level;
            end else if (state_q == CHARGE && tick) begin
                if (anim >= LVL_MAX) anim <= (level == LVL_MAX) ? '0 : level;
                else                 anim <= anim + LVL_W'(1);
            end
        end
    end

`ifdef BATT_BAR_SHUTDOWN_EN
    localparam int SW = (SHUT_TICKS > 1) ? $clog2(SHUT_TICKS + 1) : 1;

    logic [SW-1:0] shut_cnt;
    logic          shut_cond;

    assign shut_cond = (level == '0) && !charging && first_done;

    always_ff @(posedge clk) begin
        if (rst || charging) begin
            shut_cnt     <= '0;
            shutdown_req <= 1'b0;
        end else if (!shut_cond) begin
            shut_cnt <= '0;
        end else if (tick && !shutdown_req) begin
            if (int'(shut_cnt) >= SHUT_TICKS - 1) shutdown_req <= 1'b1;
            else                                  shut_cnt     <= shut_cnt + SW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_battery_bar_ctrl.sv
// Directed bench for battery_bar_ctrl with hand-computed expectations.
module tb_battery_bar_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       adc_valid = 1'b0;
    logic [7:0] adc_data = '0;
    logic       charging = 1'b0;
    logic [3:0] level;
    logic [7:0] led_bar;
    logic       low_batt;
`ifdef BATT_BAR_SHUTDOWN_EN
    logic       shutdown_req;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    int         ch_idx [8];
    logic [7:0] ch_val [8];
    int         nch;
    int         bad;
    logic [7:0] prev;

    always #5 clk = ~clk;

    battery_bar_ctrl #(
        .ADC_W       (8),
        .AVG_LOG2    (2),
        .HOLD_WIN    (3),
        .TICK_DIV    (4),
        .BLINK_TICKS (2),
        .LOW_LEVEL   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .adc_valid (adc_valid),
        .adc_data  (adc_data),
        .charging  (charging),
        .level     (level),
        .led_bar   (led_bar),
        .low_batt  (low_batt)
`ifdef BATT_BAR_SHUTDOWN_EN
        ,
        .shutdown_req (shutdown_req)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One full window of four identical samples, then let level and bar settle.
    task automatic send_window(input logic [7:0] v);
        for (int i = 0; i < 4; i++) begin
            adc_valid = 1'b1;
            adc_data  = v;
            step(1);
        end
        adc_valid = 1'b0;
        step(3);
    endtask

    // Record led_bar changes over n cycles.
    task automatic capture(input int n);
        nch = 0;
        bad = 0;
        prev = led_bar;
        for (int i = 0; i < 8; i++) begin
            ch_idx[i] = 0;
            ch_val[i] = '0;
        end
        for (int c = 1; c <= n; c++) begin
            step(1);
            if (led_bar != prev && nch < 8) begin
                ch_idx[nch] = c;
                ch_val[nch] = led_bar;
                nch++;
            end
            prev = led_bar;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step(2);
        rst = 1'b0;
        chk("rst_level", level, 0);
        chk("rst_led", led_bar, 8'h00);
        chk("rst_low", low_batt, 0);

        // First window loads directly.
        send_window(8'd255);
        chk("w255_level", level, 8);
        chk("w255_led", led_bar, 8'hFF);
        chk("w255_low", low_batt, 0);

        // Debounce: level holds for two windows, moves on the third.
        send_window(8'd128);
        chk("h1_level", level, 8);
        send_window(8'd128);
        chk("h2_level", level, 8);
        send_window(8'd128);
        chk("h3_level", level, 4);
        chk("h3_led", led_bar, 8'h0F);
        send_window(8'd128);
        chk("h4_level", level, 4);

        // Quantiser edges.
        repeat (2) send_window(8'd28);
        chk("q28_hold", level, 4);
        send_window(8'd28);
        chk("q28_level", level, 0);
        repeat (3) send_window(8'd29);
        chk("q29_level", level, 1);
        repeat (3) send_window(8'd0);
        chk("q0_level", level, 0);
        chk("q0_led", led_bar, 8'h00);
        repeat (3) send_window(8'd227);
        chk("q227_level", level, 7);
        chk("q227_led", led_bar, 8'h7F);
        chk("q227_low", low_batt, 0);

        // Low battery blink at level 2.
        repeat (3) send_window(8'd64);
        chk("low_level", level, 2);
        for (int i = 0; i < 20 && !low_batt; i++) step(1);
        chk("low_enter", low_batt, 1);
        nch = 0;
        capture(48);
        for (int k = 0; k < 8; k++) begin
            if (k < nch && ch_val[k] != 8'h03 && ch_val[k] != 8'h00) bad++;
        end
        chk("blink_vals", bad, 0);
        chk("blink_edges", (nch >= 4) ? 1 : 0, 1);
        for (int k = 0; k < 3; k++) chk("blink_run", ch_idx[k+1] - ch_idx[k], 8);
        chk("blink_low", low_batt, 1);

        repeat (3) send_window(8'd150);
        chk("up5_level", level, 5);
        chk("up5_led", led_bar, 8'h1F);
        chk("up5_low", low_batt, 0);

        // Charging animation from level 5.
        charging = 1'b1;
        step(2);
        chk("chg_first", led_bar, 8'h1F);
        capture(28);
        chk("chg_v0", ch_val[0], 8'h3F);
        chk("chg_v1", ch_val[1], 8'h7F);
        chk("chg_v2", ch_val[2], 8'hFF);
        chk("chg_v3", ch_val[3], 8'h1F);
        chk("chg_v4", ch_val[4], 8'h3F);
        for (int k = 0; k < 4; k++) chk("chg_run", ch_idx[k+1] - ch_idx[k], 4);
        charging = 1'b0;
        step(2);
        chk("chg_exit_led", led_bar, 8'h1F);
        chk("chg_exit_low", low_batt, 0);

        // Reset mid-window and mid-CHARGE.
        charging = 1'b1;
        step(6);
        for (int i = 0; i < 2; i++) begin
            adc_valid = 1'b1;
            adc_data  = 8'd0;
            step(1);
        end
        adc_valid = 1'b0;
        rst = 1'b1;
        charging = 1'b0;
        step(1);
        chk("mrst_level", level, 0);
        chk("mrst_led", led_bar, 8'h00);
        chk("mrst_low", low_batt, 0);
        rst = 1'b0;
        send_window(8'd128);
        chk("mrst_w_level", level, 4);
        chk("mrst_w_led", led_bar, 8'h0F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/battery_bar_ctrl.md
Name: battery_bar_ctrl

Overview:
- Sequences the 8-LED battery bar from raw battery ADC samples.
- Averages samples, quantises the average to a 0..8 level, and debounces level changes with a hold count.
- Drives the bar pattern for three modes: normal fill, low-battery blink and charging animation.
- Sits between the battery ADC front end and the LED bar pins.

Parameters:
- ADC_W, 8, ADC sample width in bits.
- AVG_LOG2, 2, log2 of the number of samples per averaging window.
- HOLD_WIN, 3, consecutive windows a new raw level must persist before the displayed level changes.
- TICK_DIV, 50000, clk cycles per animation tick.
- BLINK_TICKS, 8, ticks per blink half-period.
- LOW_LEVEL, 2, displayed level at or below which low-battery mode applies.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- adc_valid  in  1  one-cycle strobe, adc_data valid.
- adc_data  in  ADC_W  battery voltage sample.
- charging  in  1  charger present; synchronous, level-sensitive.
- level  out  4  displayed level, 0..8.
- led_bar  out  8  thermometer bar pattern; bit0 is the lowest LED.
- low_batt  out  1  high in LOW_BLINK state.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset values: level=0, led_bar=0, low_batt=0, state=NORMAL. Accumulator, sample count, hold count, tick prescaler, blink and animation counters all 0. first_done=0.
- Averaging:
  - On adc_valid, add adc_data into an accumulator of width ADC_W+AVG_LOG2 (no overflow possible).
  - After 2^AVG_LOG2 samples: avg = acc >> AVG_LOG2. Accumulator and count clear in the same cycle, and that cycle's adc_valid sample is the first of the next window.
- Quantise: raw = (avg*9) >> ADC_W, computed at ADC_W+4 bits, giving 0..8.
- Window-done is registered one cycle after the final sample of the window.
- Debounce:
  - If first_done=0: load level=raw, set first_done.
  - Else if raw==level: hold count = 0.
  - Else: increment hold count. Reaching HOLD_WIN loads level=raw and clears the count.
  - A raw value different from the previous candidate restarts the count at 1.
- Tick: a 1-cycle pulse every TICK_DIV clk cycles, free-running from reset.
- State machine (evaluated every cycle, charging has priority):
  - NORMAL: led_bar = thermometer(level). Go to CHARGE if charging. Else go to LOW_BLINK if level<=LOW_LEVEL and first_done.
  - LOW_BLINK: low_batt=1. led_bar = thermometer(level) during blink-on phase, 0 during off phase. Phase toggles every BLINK_TICKS ticks and starts in on-phase with the blink counter at 0 on entry.
    - Go to CHARGE if charging.
    - Go to NORMAL if level>LOW_LEVEL.
    - level=0 in this state gives an all-off bar.
  - CHARGE: anim starts at level on entry and increments on each tick. After reaching 8 it wraps to level, or to 0 if level==8.
    - led_bar = thermometer(anim).
    - Leaving CHARGE (charging=0) goes to NORMAL the next cycle.
    - A level update while in CHARGE takes effect at the next wrap.
- Outputs are registered, so a state or level change appears on led_bar one clk later.
- Reset mid-window discards the partial accumulator. Reset during any state returns to NORMAL with the bar dark.

Optional Feature:
- Macro: BATT_BAR_SHUTDOWN_EN.
- Defined:
  - Adds output port shutdown_req (1 bit) and parameter SHUT_TICKS (default 64).
  - shutdown_req asserts when level==0, charging=0 and first_done have held for SHUT_TICKS consecutive ticks.
  - shutdown_req is sticky until rst or charging=1. Reset value 0.
- Undefined: no port, no counter. Behaviour is otherwise identical.

Decomposition:
- Shared package batt_pkg:
  - state enum {NORMAL, LOW_BLINK, CHARGE}.
  - LVL_W=4 and LVL_MAX=8 constants.
  - thermometer(level) function: 0 to all-off, 8 or above to all-on.
- One sub-module: batt_level_filter. It holds the averaging, quantise and debounce logic and outputs level and first_done.
- The FSM, tick prescaler and bar driver stay in the top module.

Test Plan (ADC_W=8, AVG_LOG2=2, HOLD_WIN=3, TICK_DIV=4, BLINK_TICKS=2, LOW_LEVEL=2):
- Reset, then 4 samples of 255 -> level=8, led_bar=8'hFF, low_batt=0.
- After level=8, feed 4 windows of value 128 -> level stays 8 for 2 windows, becomes 4 after the 3rd window, led_bar=8'h0F.
- Quantise edges: windows of 28 -> raw 0; 29 -> raw 1; 0 -> 0; avg 227 -> raw 7. Check each after hold.
- level=2, charging=0 -> LOW_BLINK, low_batt=1. led_bar alternates 8'h03 / 8'h00 every 8 clk cycles. Raising to level 5 returns to NORMAL with 8'h1F.
- level=5 with charging=1 -> led_bar steps 8'h1F,3F,7F,FF,1F every 4 clk cycles. Dropping charging -> 8'h1F next cycle.
- rst asserted mid-window and mid-CHARGE -> all outputs 0 the next cycle. The next full window loads level directly, with no hold.
